// File: rtl/rtc_char_formatter_if.sv
// Character RAM write port: valid/ready, one ASCII character per transfer.
interface rtc_char_formatter_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              char_we;
  logic [ADDR_W-1:0] char_addr;
  logic [7:0]        char_data;
  logic              char_ready;

  modport master (
    output char_we,
    output char_addr,
    output char_data,
    input  char_ready
  );

  modport slave (
    input  char_we,
    input  char_addr,
    input  char_data,
    output char_ready
  );
endinterface

// File: rtl/rtc_char_formatter.sv
// RTC display formatter: snapshots BCD time/date/day/timer/ring on refresh and
// streams 28 ASCII characters into the text-mode character RAM.
// Optional macro BLINK_COLON_EN: row-0 colons become spaces on odd seconds.
module rtc_char_formatter #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ROW_W     = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh,
  input  logic [7:0] seg,
  input  logic [7:0] min,
  input  logic [7:0] hor,
  input  logic [7:0] dia,
  input  logic [7:0] mes,
  input  logic [7:0] year,
  input  logic [7:0] sd,
  input  logic [7:0] segt,
  input  logic [7:0] mint,
  input  logic [7:0] hort,
  input  logic       ring,
  rtc_char_formatter_if.master char_if,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  typedef struct packed {
    logic [7:0] seg, min, hor, dia, mes, year, sd, segt, mint, hort;
    logic       ring;
  } snap_t;

  localparam logic [4:0] LastIdx = 5'd27;

  state_e            state_q;
  snap_t             snap_q, snap_live;
  logic [4:0]        idx_q, idx_nxt;
  logic              pending_q, busy_q, done_q, we_q, start;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;

  // BCD nibble to ASCII digit; non-decimal nibbles show as '-'.
  function automatic logic [7:0] digit(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h2D;
  endfunction

  // Eight-character "AB<sep>CD<sep>EF" field built from three BCD bytes.
  function automatic logic [7:0] fmt8(input logic [2:0] pos, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c,
                                      input logic [7:0] sep);
    logic [7:0] r;
    r = sep;
    unique case (pos)
      3'd0: r = digit(a[7:4]);
      3'd1: r = digit(a[3:0]);
      3'd3: r = digit(b[7:4]);
      3'd4: r = digit(b[3:0]);
      3'd6: r = digit(c[7:4]);
      3'd7: r = digit(c[3:0]);
      default: r = sep;
    endcase
    return r;
  endfunction

  // Three-letter Spanish day name; out-of-range codes show "---".
  function automatic logic [7:0] day_char(input logic [7:0] d, input logic [1:0] k);
    logic [23:0] name;
    case (d)
      8'd1:    name = "LUN";
      8'd2:    name = "MAR";
      8'd3:    name = "MIE";
      8'd4:    name = "JUE";
      8'd5:    name = "VIE";
      8'd6:    name = "SAB";
      8'd7:    name = "DOM";
      default: name = "---";
    endcase
    case (k)
      2'd0:    return name[23:16];
      2'd1:    return name[15:8];
      default: return name[7:0];
    endcase
  endfunction

  function automatic logic [7:0] char_at(input logic [4:0] idx, input snap_t s);
    logic [7:0] colon;
    logic [7:0] r;
    colon = 8'h3A;
`ifdef BLINK_COLON_EN
    if (s.seg[0]) colon = 8'h20;
`endif
    if (idx < 5'd8)       r = fmt8(idx[2:0], s.hor, s.min, s.seg, colon);
    else if (idx < 5'd16) r = fmt8(3'(idx - 5'd8), s.dia, s.mes, s.year, 8'h2F);
    else if (idx < 5'd19) r = day_char(s.sd, 2'(idx - 5'd16));
    else if (idx < 5'd27) r = fmt8(3'(idx - 5'd19), s.hort, s.mint, s.segt, 8'h3A);
    else                  r = s.ring ? 8'h2A : 8'h20;
    return r;
  endfunction

  // Screen position of each character; wraps silently at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_at(input logic [4:0] idx);
    logic [31:0] row, col, a;
    if (idx < 5'd8)       begin row = 32'd0; col = 32'(idx); end
    else if (idx < 5'd16) begin row = 32'd1; col = 32'(idx) - 32'd8; end
    else if (idx < 5'd19) begin row = 32'd1; col = 32'(idx) - 32'd7; end
    else if (idx < 5'd27) begin row = 32'd2; col = 32'(idx) - 32'd19; end
    else                  begin row = 32'd2; col = 32'd9; end
    a = BASE_ADDR + row * ROW_W + col;
    return a[ADDR_W-1:0];
  endfunction

  // Live inputs gathered for snapshotting; frame start decision.
  always_comb begin
    snap_live      = '0;
    snap_live.seg  = seg;
    snap_live.min  = min;
    snap_live.hor  = hor;
    snap_live.dia  = dia;
    snap_live.mes  = mes;
    snap_live.year = year;
    snap_live.sd   = sd;
    snap_live.segt = segt;
    snap_live.mint = mint;
    snap_live.hort = hort;
    snap_live.ring = ring;
    idx_nxt        = idx_q + 5'd1;
    start = ((state_q == StIdle) && (refresh || pending_q)) ||
            ((state_q == StDone) && pending_q);
  end

  // Frame FSM with registered write port, busy and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        snap_q    <= snap_live;
        idx_q     <= '0;
        state_q   <= StWrite;
        busy_q    <= 1'b1;
        we_q      <= 1'b1;
        addr_q    <= addr_at(5'd0);
        data_q    <= char_at(5'd0, snap_live);
        // A refresh on the DONE->WRITE edge belongs to the next frame.
        pending_q <= (state_q == StDone) && refresh;
      end else begin
        unique case (state_q)
          StIdle: ;
          StWrite: begin
            if (refresh) pending_q <= 1'b1;
            if (char_if.char_ready) begin
              if (idx_q == LastIdx) begin
                we_q    <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                idx_q  <= idx_nxt;
                addr_q <= addr_at(idx_nxt);
                data_q <= char_at(idx_nxt, snap_q);
              end
            end
          end
          StDone: begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            pending_q <= refresh;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign char_if.char_we   = we_q;
  assign char_if.char_addr = addr_q;
  assign char_if.char_data = data_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_rtc_char_formatter.sv
// Scoreboard bench for rtc_char_formatter: directed frames with hand-written
// expected screen contents; a negedge monitor checks every presented write.
module tb_rtc_char_formatter;

  logic clk = 1'b0;
  logic reset, refresh, ring, busy, done;
  logic [7:0] seg, min, hor, dia, mes, year, sd, segt, mint, hort;

  rtc_char_formatter_if #(.ADDR_W(6)) cif ();

  rtc_char_formatter #(.ADDR_W(6), .ROW_W(16), .BASE_ADDR(0)) dut (
    .clk     (clk),
    .reset   (reset),
    .refresh (refresh),
    .seg     (seg),
    .min     (min),
    .hor     (hor),
    .dia     (dia),
    .mes     (mes),
    .year    (year),
    .sd      (sd),
    .segt    (segt),
    .mint    (mint),
    .hort    (hort),
    .ring    (ring),
    .char_if (cif),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  bit toggle_en = 1'b0;
  int ph = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic set_in(input logic [7:0] h, m, s, d, mo, y, w, ht, mt, st,
                        input logic r);
    hor = h; min = m; seg = s; dia = d; mes = mo; year = y; sd = w;
    hort = ht; mint = mt; segt = st; ring = r;
  endtask

  // Expected frame: row 0 at 0, row 1 at 16, day at 25, row 2 at 32, ring at 41.
  task automatic push_frame(input string r0, input string r1, input string dy,
                            input string r2, input byte rc);
    for (int i = 0; i < 8; i++) exp_q.push_back({6'(i), r0[i]});
    for (int i = 0; i < 8; i++) exp_q.push_back({6'(16 + i), r1[i]});
    for (int i = 0; i < 3; i++) exp_q.push_back({6'(25 + i), dy[i]});
    for (int i = 0; i < 8; i++) exp_q.push_back({6'(32 + i), r2[i]});
    exp_q.push_back({6'd41, rc});
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(posedge clk);
    #2 refresh = 1'b0;
  endtask

  // Returns edges until done is seen, or -1 when the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #2;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 300 cycles");
    end
  endtask

  // Monitor: every presented write must match the scoreboard head; pop on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cif.char_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                   cif.char_addr, cif.char_data);
          if (cif.char_ready) xfers++;
        end else begin
          if ({cif.char_addr, cif.char_data} !== exp_q[0]) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     cif.char_addr, cif.char_data, exp_q[0][13:8], exp_q[0][7:0]);
          end
          if (cif.char_ready) begin
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end
    end
  end

  // Back-pressure pattern 1,0,0,1 when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        cif.char_ready = (ph == 1 || ph == 2) ? 1'b0 : 1'b1;
        ph = (ph + 1) % 4;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    reset = 1'b1;
    refresh = 1'b0;
    cif.char_ready = 1'b0;
    set_in(8'h12, 8'h34, 8'h56, 8'h07, 8'h05, 8'h17, 8'd3, 8'h00, 8'h01, 8'h30, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("reset_we", cif.char_we, 0);
    check("reset_addr", cif.char_addr, 0);
    check("reset_data", cif.char_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    cif.char_ready = 1'b1;
    @(posedge clk);
    #2;

    // Basic frame, ready tied high.
    push_frame("12:34:56", "07/05/17", "MIE", "00:01:30", 8'h20);
    base = xfers;
    pulse_refresh();
    check("busy_after_refresh", busy, 1);
    check("we_after_refresh", cif.char_we, 1);
    wait_done(lat);
    check("done_latency", lat, 28);
    check("transfers_f1", xfers - base, 28);
    check("busy_in_done", busy, 1);
    @(posedge clk);
    #2;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);

    // Back-pressure: stalls must hold addr/data and lose nothing.
    set_in(8'h23, 8'h59, 8'h08, 8'h31, 8'h12, 8'h99, 8'd7, 8'h99, 8'h59, 8'h59, 1'b1);
    push_frame("23:59:08", "31/12/99", "DOM", "99:59:59", 8'h2A);
    base = xfers;
    ph = 0;
    toggle_en = 1'b1;
    pulse_refresh();
    wait_done(lat);
    toggle_en = 1'b0;
    #2 cif.char_ready = 1'b1;
    check("transfers_stall", xfers - base, 28);
    check("queue_empty_stall", exp_q.size(), 0);
    @(posedge clk);
    #2;

    // Three refreshes during a frame collapse into one extra frame on new inputs.
    set_in(8'h12, 8'h34, 8'h56, 8'h07, 8'h05, 8'h17, 8'd3, 8'h00, 8'h01, 8'h30, 1'b0);
    push_frame("12:34:56", "07/05/17", "MIE", "00:01:30", 8'h20);
    base = xfers;
    pulse_refresh();
    for (int p = 0; p < 3; p++) begin
      repeat (3) @(posedge clk);
      #2;
      pulse_refresh();
    end
    set_in(8'h23, 8'h59, 8'h08, 8'h31, 8'h12, 8'h99, 8'd7, 8'h99, 8'h59, 8'h59, 1'b1);
    push_frame("23:59:08", "31/12/99", "DOM", "99:59:59", 8'h2A);
    wait_done(lat);
    @(posedge clk);
    #2;
    check("extra_frame_we", cif.char_we, 1);
    check("extra_frame_busy", busy, 1);
    wait_done(lat);
    check("extra_frame_latency", lat, 28);
    repeat (5) @(posedge clk);
    #2;
    check("no_third_frame_busy", busy, 0);
    check("transfers_two_frames", xfers - base, 56);

    // Non-decimal nibbles, invalid day, ring set.
    set_in(8'h12, 8'h34, 8'h5C, 8'h07, 8'h05, 8'hFA, 8'd0, 8'h00, 8'h01, 8'h30, 1'b1);
    push_frame("12:34:5-", "07/05/--", "---", "00:01:30", 8'h2A);
    pulse_refresh();
    wait_done(lat);
    check("done_latency_bad_bcd", lat, 28);
    @(posedge clk);
    #2;

    // Reset mid-frame at idx 10, then a clean restart from idx 0.
    set_in(8'h12, 8'h34, 8'h56, 8'h07, 8'h05, 8'h17, 8'd3, 8'h00, 8'h01, 8'h30, 1'b0);
    push_frame("12:34:56", "07/05/17", "MIE", "00:01:30", 8'h20);
    base = xfers;
    pulse_refresh();
    for (int k = 0; k < 100 && (xfers - base) < 10; k++) begin
      @(posedge clk);
      #2;
    end
    check("reach_idx10", xfers - base, 10);
    reset = 1'b1;
    #1;
    check("midreset_we", cif.char_we, 0);
    check("midreset_addr", cif.char_addr, 0);
    check("midreset_data", cif.char_data, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    exp_q.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;
    check("post_reset_idle_we", cif.char_we, 0);
    set_in(8'h23, 8'h59, 8'h08, 8'h31, 8'h12, 8'h99, 8'd7, 8'h99, 8'h59, 8'h59, 1'b1);
    push_frame("23:59:08", "31/12/99", "DOM", "99:59:59", 8'h2A);
    pulse_refresh();
    wait_done(lat);
    check("restart_latency", lat, 28);
    @(posedge clk);
    #2;

    // Odd and even seconds; colons on row 0 blink only with the option built in.
    set_in(8'h12, 8'h34, 8'h57, 8'h07, 8'h05, 8'h17, 8'd1, 8'h00, 8'h01, 8'h31, 1'b0);
`ifdef BLINK_COLON_EN
    push_frame("12 34 57", "07/05/17", "LUN", "00:01:31", 8'h20);
`else
    push_frame("12:34:57", "07/05/17", "LUN", "00:01:31", 8'h20);
`endif
    pulse_refresh();
    wait_done(lat);
    @(posedge clk);
    #2;
    set_in(8'h12, 8'h34, 8'h58, 8'h07, 8'h05, 8'h17, 8'd4, 8'h00, 8'h01, 8'h31, 1'b0);
    push_frame("12:34:58", "07/05/17", "JUE", "00:01:31", 8'h20);
    pulse_refresh();
    wait_done(lat);
    repeat (3) @(posedge clk);
    #2;
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
